// File: rtl/systolic_array_stream.sv
// Output-stationary ROWS x COLS signed MAC array computing C = A*B over a K-slice stream.
// Skew is applied internally; results drain one row of C per beat.
module systolic_array_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int ROWS       = 3,
  parameter int COLS       = 3
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [ROWS*DATA_WIDTH-1:0]                a_in,
  input  logic [COLS*DATA_WIDTH-1:0]                b_in,
  input  logic                                      in_valid,
  input  logic                                      in_last,
  output logic                                      in_ready,
  output logic [COLS*ACC_WIDTH-1:0]                 c_out,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] c_row,
  output logic                                      c_valid,
  output logic                                      c_last,
  input  logic                                      c_ready
);

  localparam int RW         = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW         = $clog2(ROWS + COLS);
  localparam int FLUSH_LAST = ROWS + COLS - 2;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [RW-1:0]   r_row;

  logic            w_accept;
  logic            w_clear;

  logic [ROWS-1:0][DATA_WIDTH-1:0] w_apre;
  logic [ROWS-1:0]                 w_vpre;
  logic [COLS-1:0][DATA_WIDTH-1:0] w_bpre;

  logic signed [DATA_WIDTH-1:0]   r_a   [ROWS][COLS];
  logic signed [DATA_WIDTH-1:0]   r_b   [ROWS][COLS];
  logic                           r_v   [ROWS][COLS];
  logic signed [ACC_WIDTH-1:0]    r_acc [ROWS][COLS];
  logic signed [2*DATA_WIDTH-1:0] w_prod [ROWS][COLS];
  logic signed [ACC_WIDTH-1:0]    w_ext  [ROWS][COLS];

  assign in_ready = !rst && ((r_state == IDLE) || (r_state == LOAD));
  assign w_accept = in_valid && in_ready;
  assign w_clear  = w_accept && (r_state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_row   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= in_last ? FLUSH : LOAD;
            r_cnt   <= '0;
          end
        end
        LOAD: begin
          if (w_accept && in_last) begin
            r_state <= FLUSH;
            r_cnt   <= '0;
          end
        end
        FLUSH: begin
          if (r_cnt == CW'(FLUSH_LAST)) begin
            r_state <= DRAIN;
            r_row   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DRAIN: begin
          if (c_ready) begin
            if (r_row == RW'(ROWS - 1)) begin
              r_state <= IDLE;
              r_row   <= '0;
            end else begin
              r_row <= r_row + RW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Lane i gets i skew registers here; the final stage is the PE(i,0) input register r_a[i][0].
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_askew
    if (gi == 0) begin : g_direct
      assign w_apre[gi] = a_in[DATA_WIDTH-1:0];
      assign w_vpre[gi] = w_accept;
    end else begin : g_chain
      logic [DATA_WIDTH-1:0] r_d  [gi];
      logic                  r_dv [gi];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned s = 0; s < gi; s++) begin
            r_d[s]  <= '0;
            r_dv[s] <= 1'b0;
          end
        end else begin
          r_d[0]  <= a_in[gi*DATA_WIDTH +: DATA_WIDTH];
          r_dv[0] <= w_accept;
          for (int unsigned s = 1; s < gi; s++) begin
            r_d[s]  <= r_d[s-1];
            r_dv[s] <= r_dv[s-1];
          end
        end
      end
      assign w_apre[gi] = r_d[gi-1];
      assign w_vpre[gi] = r_dv[gi-1];
    end
  end

  for (genvar gj = 0; gj < COLS; gj++) begin : g_bskew
    if (gj == 0) begin : g_direct
      assign w_bpre[gj] = b_in[DATA_WIDTH-1:0];
    end else begin : g_chain
      logic [DATA_WIDTH-1:0] r_d [gj];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned s = 0; s < gj; s++) r_d[s] <= '0;
        end else begin
          r_d[0] <= b_in[gj*DATA_WIDTH +: DATA_WIDTH];
          for (int unsigned s = 1; s < gj; s++) r_d[s] <= r_d[s-1];
        end
      end
      assign w_bpre[gj] = r_d[gj-1];
    end
  end

  // Full-width signed product, then sign-extended or truncated to the accumulator width.
  always_comb begin
    for (int unsigned i = 0; i < ROWS; i++) begin
      for (int unsigned j = 0; j < COLS; j++) begin
        w_prod[i][j] = r_a[i][j] * r_b[i][j];
        w_ext[i][j]  = ACC_WIDTH'(w_prod[i][j]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ROWS; i++) begin
        for (int unsigned j = 0; j < COLS; j++) begin
          r_a[i][j]   <= '0;
          r_b[i][j]   <= '0;
          r_v[i][j]   <= 1'b0;
          r_acc[i][j] <= '0;
        end
      end
    end else begin
      for (int unsigned i = 0; i < ROWS; i++) begin
        r_a[i][0] <= w_apre[i];
        r_v[i][0] <= w_vpre[i];
        for (int unsigned j = 1; j < COLS; j++) begin
          r_a[i][j] <= r_a[i][j-1];
          r_v[i][j] <= r_v[i][j-1];
        end
      end
      for (int unsigned j = 0; j < COLS; j++) begin
        r_b[0][j] <= w_bpre[j];
        for (int unsigned i = 1; i < ROWS; i++) begin
          r_b[i][j] <= r_b[i-1][j];
        end
      end
      for (int unsigned i = 0; i < ROWS; i++) begin
        for (int unsigned j = 0; j < COLS; j++) begin
          if (w_clear) begin
            r_acc[i][j] <= '0;
          end else if (r_v[i][j]) begin
            r_acc[i][j] <= r_acc[i][j] + w_ext[i][j];
          end
        end
      end
    end
  end

  always_comb begin
    c_out = '0;
    if (r_state == DRAIN) begin
      for (int unsigned j = 0; j < COLS; j++) begin
        c_out[j*ACC_WIDTH +: ACC_WIDTH] = r_acc[r_row][j];
      end
    end
  end

  assign c_valid = (r_state == DRAIN);
  assign c_row   = r_row;
  assign c_last  = c_valid && (r_row == RW'(ROWS - 1));

endmodule

// File: tb/tb_systolic_array_stream.sv
// Directed bench for systolic_array_stream: matrix-product scoreboard plus literal pins.
module tb_systolic_array_stream;

  localparam int DW = 16;
  localparam int AW = 40;
  localparam int R  = 3;
  localparam int C  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [R*DW-1:0] a_in = '0;
  logic [C*DW-1:0] b_in = '0;
  logic in_valid = 1'b0;
  logic in_last  = 1'b0;
  logic in_ready;
  logic [C*AW-1:0] c_out;
  logic [1:0] c_row;
  logic c_valid;
  logic c_last;
  logic c_ready = 1'b1;

  logic [15:0] w_a = '0;
  logic [15:0] w_b = '0;
  logic w_in_valid = 1'b0;
  logic w_in_last  = 1'b0;
  logic w_in_ready;
  logic [31:0] w_c_out;
  logic [0:0] w_c_row;
  logic w_c_valid;
  logic w_c_last;
  logic w_c_ready = 1'b1;

  systolic_array_stream #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .ROWS(R), .COLS(C)) u_dut (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .c_out(c_out), .c_row(c_row), .c_valid(c_valid), .c_last(c_last),
    .c_ready(c_ready)
  );

  systolic_array_stream #(.DATA_WIDTH(16), .ACC_WIDTH(32), .ROWS(1), .COLS(1)) u_wrap (
    .clk(clk), .rst(rst), .a_in(w_a), .b_in(w_b), .in_valid(w_in_valid), .in_last(w_in_last),
    .in_ready(w_in_ready), .c_out(w_c_out), .c_row(w_c_row), .c_valid(w_c_valid),
    .c_last(w_c_last), .c_ready(w_c_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  bit first_pending = 0;
  bit bp_en = 0;
  int bp_cnt = 0;

  int Am [R][4];
  int Bm [4][C];

  typedef struct {
    logic [C*AW-1:0] data;
    int              row;
    bit              last;
  } row_t;
  row_t exp_q [$];

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic longint model_c(input int r, input int j, input int K);
    longint s = 0;
    for (int k = 0; k < K; k++) s += longint'(Am[r][k]) * longint'(Bm[k][j]);
    return s;
  endfunction

  task automatic push_expected(input int K);
    for (int r = 0; r < R; r++) begin
      row_t e;
      for (int j = 0; j < C; j++) begin
        longint s;
        s = model_c(r, j, K);
        e.data[j*AW +: AW] = s[AW-1:0];
      end
      e.row  = r;
      e.last = (r == R - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic run_op(input int K, input int gap);
    push_expected(K);
    for (int k = 0; k < K; k++) begin
      for (int i = 0; i < R; i++) a_in[i*DW +: DW] = DW'(Am[i][k]);
      for (int j = 0; j < C; j++) b_in[j*DW +: DW] = DW'(Bm[k][j]);
      in_valid = 1'b1;
      in_last  = (k == K - 1);
      @(negedge clk);
      chk("in_ready_accept", in_ready, 1);
      if (k == K - 1) begin
        last_acc = cyc;
        first_pending = 1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (k < K - 1) repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_complete", exp_q.size() == 0, 1);
    @(negedge clk);
    chk("in_ready_after_drain", in_ready, 1);
    chk("c_valid_after_drain", c_valid, 0);
    @(posedge clk); #1;
  endtask

  always @(posedge clk) begin
    #1;
    if (bp_en && c_valid && c_row == 2'd1 && bp_cnt < 4) begin
      c_ready = 1'b0;
      bp_cnt++;
    end else begin
      c_ready = 1'b1;
    end
  end

  logic [C*AW-1:0] held_out;
  logic [1:0]      held_row;
  bit              hold_pending = 0;

  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 0;
    end else begin
      if (hold_pending) begin
        chk("hold_c_valid", c_valid, 1);
        chk("hold_c_out", c_out, held_out);
        chk("hold_c_row", c_row, held_row);
      end
      hold_pending = 0;
      if (c_valid) begin
        if (first_pending) begin
          chk("first_valid_latency", cyc - last_acc, R + C);
          first_pending = 0;
        end
        if (!c_ready) begin
          held_out = c_out;
          held_row = c_row;
          hold_pending = 1;
        end else if (exp_q.size() == 0) begin
          chk("unexpected_c_valid", c_valid, 0);
        end else begin
          row_t e;
          e = exp_q.pop_front();
          chk("c_out", c_out, e.data);
          chk("c_row", c_row, e.row);
          chk("c_last", c_last, e.last);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_c_valid", c_valid, 0);
    chk("rst_c_last", c_last, 0);
    chk("rst_c_row", c_row, 0);
    chk("rst_c_out", c_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Test 1: identity B, timing, in_valid ignored during FLUSH
    Am = '{'{1, 2, 3, 0}, '{4, 5, 6, 0}, '{7, 8, 9, 0}};
    Bm = '{'{1, 0, 0}, '{0, 1, 0}, '{0, 0, 1}, '{0, 0, 0}};
    chk("pin_identity_c12", model_c(1, 2, 3), 6);
    chk("pin_identity_c21", model_c(2, 1, 3), 8);
    run_op(3, 0);
    a_in = '1; b_in = '1; in_valid = 1'b1; in_last = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("flush_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    wait_drain();

    // Test 2: signed operands with a bubble between slices
    Am = '{'{-1, 2, 0, 0}, '{3, -4, 0, 0}, '{0, 5, 0, 0}};
    Bm = '{'{2, -3, 1}, '{6, 0, -2}, '{0, 0, 0}, '{0, 0, 0}};
    chk("pin_signed_c00", model_c(0, 0, 2), 10);
    chk("pin_signed_c10", model_c(1, 0, 2), -18);
    chk("pin_signed_c12", model_c(1, 2, 2), 11);
    chk("pin_signed_c22", model_c(2, 2, 2), -10);
    run_op(2, 1);
    wait_drain();

    // Test 3: back-pressure on row 1, K=4 with extreme operands
    Am = '{'{32767, -2, 3, 4}, '{5, 6, -7, 8}, '{-9, 10, 11, -32768}};
    Bm = '{'{-32768, 2, 3}, '{-4, 5, -6}, '{7, -8, 9}, '{10, 11, -32768}};
    chk("pin_extreme_c00", model_c(0, 0, 4), -1073709056 + 8 + 21 + 40);
    bp_en = 1; bp_cnt = 0;
    run_op(4, 0);
    wait_drain();
    bp_en = 0;
    chk("backpressure_applied", bp_cnt, 4);

    // Test 4: back-to-back K=1, accumulators must be cleared by the first accept
    Am = '{'{2, 0, 0, 0}, '{2, 0, 0, 0}, '{2, 0, 0, 0}};
    Bm = '{'{2, 2, 2}, '{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}};
    chk("pin_k1_c11", model_c(1, 1, 1), 4);
    run_op(1, 0);
    wait_drain();

    // Test 5: reset during FLUSH, then a fresh op
    Am = '{'{1, 2, 3, 0}, '{4, 5, 6, 0}, '{7, 8, 9, 0}};
    Bm = '{'{3, 1, 4}, '{1, 5, 9}, '{2, 6, 5}, '{0, 0, 0}};
    run_op(3, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    first_pending = 0;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_c_valid", c_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_in_ready", in_ready, 1);
    repeat (10) begin
      @(negedge clk);
      chk("postrst_no_c_valid", c_valid, 0);
    end
    @(posedge clk); #1;
    Am = '{'{-1, 2, 0, 0}, '{3, -4, 0, 0}, '{0, 5, 0, 0}};
    Bm = '{'{2, -3, 1}, '{6, 0, -2}, '{0, 0, 0}, '{0, 0, 0}};
    run_op(2, 0);
    wait_drain();

    // Test 6: 1x1, 32-bit accumulator wraps after three (-32768)^2 products
    begin
      int n = 0;
      for (int k = 0; k < 3; k++) begin
        w_a = 16'h8000; w_b = 16'h8000;
        w_in_valid = 1'b1; w_in_last = (k == 2);
        @(negedge clk);
        chk("wrap_in_ready", w_in_ready, 1);
        @(posedge clk); #1;
      end
      w_in_valid = 1'b0; w_in_last = 1'b0;
      @(negedge clk);
      while (!w_c_valid && n < 20) begin
        @(posedge clk); #1;
        n++;
        @(negedge clk);
      end
      chk("wrap_latency", n, 1);
      chk("wrap_c_valid", w_c_valid, 1);
      chk("wrap_c_out", w_c_out, 32'hC000_0000);
      chk("wrap_c_row", w_c_row, 0);
      chk("wrap_c_last", w_c_last, 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("wrap_done_c_valid", w_c_valid, 0);
      chk("wrap_done_in_ready", w_in_ready, 1);
    end

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
